vga_scan_timing: RTL and testbench

Raster timing generator sitting directly upstream of the tic-tac-toe display stage. It produces the pixel coordinates (`row`, `col`) and the blanking flag (`vnotactive`) that the display stage consumes. It also drives the monitor sync pins and provides a frame pulse and frame counter for animation and pseudo-random sequencing. The default geometry is 640x480 at a 25 MHz pixel rate.

---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/vga_scan_timing_if.sv | 37 +++
 rtl/vga_axis_counter.sv | 63 ++++++
 rtl/vga_scan_timing.sv | 116 +++++++++++
 tb/tb_vga_scan_timing.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster timing slice: default 640x480 geometry,
// sync polarity encodings, coordinate width and counter-width helpers.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 32;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [7:0]         frame_cnt_t;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // A degenerate one-position axis still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/vga_scan_timing_if.sv
// Raster output bundle: coordinates, blanking, sync pins, pixel enable and frame info.
// The timing generator drives it through the master modport; consumers use slave.
interface vga_scan_timing_if;
  import vga_timing_pkg::*;

  coord_t     col;
  coord_t     row;
  logic       vnotactive;
  logic       hsync;
  logic       vsync;
  logic       pix_ce;
  logic       frame_start;
  frame_cnt_t frame_cnt;

  modport master (
    output col,
    output row,
    output vnotactive,
    output hsync,
    output vsync,
    output pix_ce,
    output frame_start,
    output frame_cnt
  );

  modport slave (
    input col,
    input row,
    input vnotactive,
    input hsync,
    input vsync,
    input pix_ce,
    input frame_start,
    input frame_cnt
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap strobe plus sync-window and blanking
// flags registered from the next count, so they always describe the current count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned FP     = H_FP_DEF,
  parameter int unsigned SYNC   = H_SYNC_DEF,
  parameter int unsigned BP     = H_BP_DEF,
  parameter int unsigned CNT_W  = cnt_width(axis_total(ACTIVE, FP, SYNC, BP))
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             sync_act,
  output logic             blank
);

  localparam int unsigned      TOTAL    = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [31:0]      SYNC_LO  = 32'(ACTIVE + FP);
  localparam logic [31:0]      SYNC_HI  = 32'(ACTIVE + FP + SYNC);
  localparam logic [31:0]      ACT_LIM  = 32'(ACTIVE);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  logic [31:0]      w_cnt_d_ext;
  logic             r_sync_act;
  logic             r_blank;
  logic             w_wrap;

  assign w_wrap = inc & (r_cnt == LAST);

  always_comb begin
    w_cnt_d = r_cnt;
    if (inc) begin
      w_cnt_d = w_wrap ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Compare in 32 bits: the sync window end may equal TOTAL, which need not fit CNT_W.
  assign w_cnt_d_ext = 32'(w_cnt_d);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt      <= '0;
      r_sync_act <= 1'b0;
      r_blank    <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_d;
      r_sync_act <= (w_cnt_d_ext >= SYNC_LO) && (w_cnt_d_ext < SYNC_HI);
      r_blank    <= (w_cnt_d_ext >= ACT_LIM);
    end
  end

  assign cnt      = r_cnt;
  assign wrap     = w_wrap;
  assign sync_act = r_sync_act;
  assign blank    = r_blank;

endmodule

// File: rtl/vga_scan_timing.sv
// Raster timing generator: H/V axis counters, sync polarity, pixel enable and frame
// counter. Define VGA_PIXEL_DIV2_EN to advance on every second CLK (50 MHz clock).
module vga_scan_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter logic        SYNC_POL = SYNC_ACTIVE_LOW
) (
  input  logic                CLK,
  input  logic                RST,
  vga_scan_timing_if.master   vga
);

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned H_W     = cnt_width(H_TOTAL);
  localparam int unsigned V_W     = cnt_width(V_TOTAL);

  logic           w_pix_ce;
  logic [H_W-1:0] w_hcnt;
  logic [V_W-1:0] w_vcnt;
  logic           w_h_wrap;
  logic           w_v_wrap;
  logic           w_h_sync_act;
  logic           w_v_sync_act;
  logic           w_h_blank;
  logic           w_v_blank;
  logic           w_frame_wrap;

  logic           r_frame_start;
  frame_cnt_t     r_frame_cnt;

`ifdef VGA_PIXEL_DIV2_EN
  logic r_div;

  // Low on the first cycle after reset release, then alternates.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_div <= 1'b0;
    end else begin
      r_div <= ~r_div;
    end
  end

  assign w_pix_ce = r_div;
`else
  assign w_pix_ce = 1'b1;
`endif

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .CNT_W  (H_W)
  ) u_h_axis (
    .CLK      (CLK),
    .RST      (RST),
    .inc      (w_pix_ce),
    .cnt      (w_hcnt),
    .wrap     (w_h_wrap),
    .sync_act (w_h_sync_act),
    .blank    (w_h_blank)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .CNT_W  (V_W)
  ) u_v_axis (
    .CLK      (CLK),
    .RST      (RST),
    .inc      (w_h_wrap),
    .cnt      (w_vcnt),
    .wrap     (w_v_wrap),
    .sync_act (w_v_sync_act),
    .blank    (w_v_blank)
  );

  // The vertical axis only advances on a line wrap, so its wrap marks the frame wrap.
  assign w_frame_wrap = w_h_wrap & w_v_wrap;

  // frame_start updates only on pixel enables so it spans the whole (0,0) tick.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      if (w_pix_ce) begin
        r_frame_start <= w_frame_wrap;
      end
      if (w_frame_wrap) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign vga.col         = COORD_W'(w_hcnt);
  assign vga.row         = COORD_W'(w_vcnt);
  assign vga.vnotactive  = w_h_blank | w_v_blank;
  assign vga.hsync       = w_h_sync_act ? SYNC_POL : ~SYNC_POL;
  assign vga.vsync       = w_v_sync_act ? SYNC_POL : ~SYNC_POL;
  assign vga.pix_ce      = w_pix_ce;
  assign vga.frame_start = r_frame_start;
  assign vga.frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing: a default-geometry DUT for line behaviour and a tiny
// active-high-sync DUT for frame, vsync and reset behaviour, both checked against
// an arithmetic model of the raster driven by ticks elapsed since reset.
module tb_vga_scan_timing;

`ifdef VGA_PIXEL_DIV2_EN
  localparam bit Div2 = 1'b1;
`else
  localparam bit Div2 = 1'b0;
`endif

  // Small geometry: 12 pixels x 10 lines, hsync cols 9..10, vsync rows 7..8.
  localparam int unsigned SHA = 8, SHF = 1, SHS = 2, SHB = 1;
  localparam int unsigned SVA = 6, SVF = 1, SVS = 2, SVB = 1;
  localparam int unsigned SF  = (SHA + SHF + SHS + SHB) * (SVA + SVF + SVS + SVB);

  logic clk = 1'b0;
  logic rst_d = 1'b1;
  logic rst_s = 1'b1;
  int unsigned c_d = 0;
  int unsigned c_s = 0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vga_scan_timing_if if_d ();
  vga_scan_timing_if if_s ();

  vga_scan_timing dut_d (
    .CLK (clk),
    .RST (rst_d),
    .vga (if_d)
  );

  vga_scan_timing #(
    .H_ACTIVE (SHA), .H_FP (SHF), .H_SYNC (SHS), .H_BP (SHB),
    .V_ACTIVE (SVA), .V_FP (SVF), .V_SYNC (SVS), .V_BP (SVB),
    .SYNC_POL (1'b1)
  ) dut_s (
    .CLK (clk),
    .RST (rst_s),
    .vga (if_s)
  );

  // Clock edges since the last reset edge.
  always_ff @(posedge clk) begin
    c_d <= rst_d ? 0 : c_d + 1;
    c_s <= rst_s ? 0 : c_s + 1;
  end

  function automatic int unsigned cyc(input int unsigned t);
    return Div2 ? 2 * t : t;
  endfunction

  // Expected {col,row,vnotactive,hsync,vsync,pix_ce,frame_start,frame_cnt} after c edges.
  function automatic logic [76:0] model(input int unsigned c,
      input int unsigned ha, input int unsigned hf, input int unsigned hs, input int unsigned hb,
      input int unsigned va, input int unsigned vf, input int unsigned vs, input int unsigned vb,
      input logic pol);
    int unsigned t, ht, vt, fr, col, row;
    logic vn, hsa, vsa, fs, pce;
    logic [7:0] fc;
    t   = Div2 ? c / 2 : c;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    fr  = ht * vt;
    col = t % ht;
    row = (t / ht) % vt;
    vn  = (col >= ha) || (row >= va);
    hsa = (col >= ha + hf) && (col < ha + hf + hs);
    vsa = (row >= va + vf) && (row < va + vf + vs);
    fs  = (t != 0) && (t % fr == 0);
    fc  = 8'((t / fr) % 256);
    pce = Div2 ? ((c % 2) == 1) : 1'b1;
    return {32'(col), 32'(row), vn, hsa ? pol : ~pol, vsa ? pol : ~pol, pce, fs, fc};
  endfunction

  function automatic logic [76:0] model_d(input int unsigned c);
    return model(c, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
  endfunction

  function automatic logic [76:0] model_s(input int unsigned c);
    return model(c, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b1);
  endfunction

  function automatic logic [76:0] obs_d();
    return {if_d.col, if_d.row, if_d.vnotactive, if_d.hsync, if_d.vsync, if_d.pix_ce,
            if_d.frame_start, if_d.frame_cnt};
  endfunction

  function automatic logic [76:0] obs_s();
    return {if_s.col, if_s.row, if_s.vnotactive, if_s.hsync, if_s.vsync, if_s.pix_ce,
            if_s.frame_start, if_s.frame_cnt};
  endfunction

  task automatic test_reset();
    int k_seen;
    rst_d = 1'b1;
    rst_s = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_d = 1'b0;
    rst_s = 1'b0;
    n_cmp++;
    if ({if_d.col, if_d.row} !== 64'd0) begin
      n_err++; $display("FAIL reset_coord got col=%0d row=%0d want 0/0", if_d.col, if_d.row);
    end
    n_cmp++;
    if ({if_d.vnotactive, if_d.frame_start, if_d.frame_cnt} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_flags got vn=%b fs=%b fc=%0d want 0/0/0", if_d.vnotactive,
               if_d.frame_start, if_d.frame_cnt);
    end
    n_cmp++;
    if ({if_d.hsync, if_d.vsync} !== 2'b11) begin
      n_err++; $display("FAIL reset_sync_low_pol got %b%b want 11", if_d.hsync, if_d.vsync);
    end
    n_cmp++;
    if ({if_s.hsync, if_s.vsync} !== 2'b00) begin
      n_err++; $display("FAIL reset_sync_high_pol got %b%b want 00", if_s.hsync, if_s.vsync);
    end
    n_cmp++;
    if (if_d.pix_ce !== !Div2) begin
      n_err++; $display("FAIL reset_pix_ce got %b want %b", if_d.pix_ce, !Div2);
    end
    n_cmp++;
    if (obs_s() !== model_s(c_s)) begin
      n_err++; $display("FAIL reset_small got %h want %h", obs_s(), model_s(c_s));
    end
    k_seen = 0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (k_seen == 0 && if_d.col == 32'd1) k_seen = k;
    end
    n_cmp++;
    if (k_seen !== (Div2 ? 2 : 1)) begin
      n_err++; $display("FAIL first_advance got edge %0d want %0d", k_seen, Div2 ? 2 : 1);
    end
  endtask

  task automatic test_line_wrap();
    int unsigned n;
    rst_d = 1'b1;
    @(posedge clk);
    #1;
    rst_d = 1'b0;
    n = cyc(4800 + 760 + $urandom_range(0, 1600));
    for (int i = 0; i < int'(n); i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (obs_d() !== model_d(c_d)) begin
        n_err++; $display("FAIL line_model c=%0d got %h want %h", c_d, obs_d(), model_d(c_d));
      end
      if (c_d == cyc(4799)) begin
        n_cmp++;
        if ({if_d.col, if_d.row, if_d.vnotactive} !== {32'd799, 32'd5, 1'b1}) begin
          n_err++; $display("FAIL line_end got col=%0d row=%0d vn=%b want 799/5/1",
                            if_d.col, if_d.row, if_d.vnotactive);
        end
      end
      if (c_d == cyc(4800)) begin
        n_cmp++;
        if ({if_d.col, if_d.row, if_d.vnotactive} !== {32'd0, 32'd6, 1'b0}) begin
          n_err++; $display("FAIL line_wrap got col=%0d row=%0d vn=%b want 0/6/0",
                            if_d.col, if_d.row, if_d.vnotactive);
        end
      end
      if (c_d == cyc(4800 + 640)) begin
        n_cmp++;
        if (if_d.vnotactive !== 1'b1) begin
          n_err++; $display("FAIL blank_start got vn=%b want 1", if_d.vnotactive);
        end
      end
      if (c_d == cyc(4800 + 655) || c_d == cyc(4800 + 752)) begin
        n_cmp++;
        if (if_d.hsync !== 1'b1) begin
          n_err++; $display("FAIL hsync_edge_out col=%0d got %b want 1", if_d.col, if_d.hsync);
        end
      end
      if (c_d == cyc(4800 + 656) || c_d == cyc(4800 + 751)) begin
        n_cmp++;
        if (if_d.hsync !== 1'b0) begin
          n_err++; $display("FAIL hsync_edge_in col=%0d got %b want 0", if_d.col, if_d.hsync);
        end
      end
    end
  endtask

  task automatic test_frame_wrap();
    int unsigned n, nv, nfs;
    rst_s = 1'b1;
    @(posedge clk);
    #1;
    rst_s = 1'b0;
    nv  = 0;
    nfs = 0;
    n   = cyc(256 * SF + $urandom_range(1, SF - 1));
    for (int i = 0; i < int'(n); i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (obs_s() !== model_s(c_s)) begin
        n_err++; $display("FAIL frame_model c=%0d got %h want %h", c_s, obs_s(), model_s(c_s));
      end
      if (c_s < cyc(SF) && if_s.vsync === 1'b1) nv++;
      if (if_s.frame_start === 1'b1) nfs++;
      if (c_s == cyc(SF)) begin
        n_cmp++;
        if ({if_s.col, if_s.row, if_s.frame_start, if_s.frame_cnt} !== {64'd0, 1'b1, 8'd1}) begin
          n_err++; $display("FAIL first_frame got col=%0d row=%0d fs=%b fc=%0d want 0/0/1/1",
                            if_s.col, if_s.row, if_s.frame_start, if_s.frame_cnt);
        end
      end
      if (c_s == cyc(256 * SF)) begin
        n_cmp++;
        if ({if_s.frame_start, if_s.frame_cnt} !== {1'b1, 8'd0}) begin
          n_err++; $display("FAIL frame_cnt_wrap got fs=%b fc=%0d want 1/0",
                            if_s.frame_start, if_s.frame_cnt);
        end
      end
    end
    n_cmp++;
    if (nv !== SVS * (SHA + SHF + SHS + SHB) * (Div2 ? 2 : 1)) begin
      n_err++; $display("FAIL vsync_width got %0d cycles want %0d", nv,
                        SVS * (SHA + SHF + SHS + SHB) * (Div2 ? 2 : 1));
    end
    n_cmp++;
    if (nfs !== 256 * (Div2 ? 2 : 1)) begin
      n_err++; $display("FAIL frame_start_count got %0d want %0d", nfs, 256 * (Div2 ? 2 : 1));
    end
  endtask

  task automatic test_mid_reset();
    int unsigned t0, m;
    rst_s = 1'b1;
    @(posedge clk);
    #1;
    rst_s = 1'b0;
    t0 = 3 * SF + $urandom_range(1, SF - 1);
    for (int i = 0; i < int'(cyc(t0)); i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (obs_s() !== model_s(c_s)) begin
        n_err++; $display("FAIL mid_pre c=%0d got %h want %h", c_s, obs_s(), model_s(c_s));
      end
    end
    n_cmp++;
    if (if_s.frame_cnt !== 8'd3) begin
      n_err++; $display("FAIL mid_pre_fc got %0d want 3", if_s.frame_cnt);
    end
    rst_s = 1'b1;
    @(posedge clk);
    #1;
    rst_s = 1'b0;
    n_cmp++;
    if ({if_s.col, if_s.row, if_s.vnotactive, if_s.frame_start, if_s.frame_cnt} !== 75'd0) begin
      n_err++; $display("FAIL mid_reset got col=%0d row=%0d vn=%b fs=%b fc=%0d want zeros",
                        if_s.col, if_s.row, if_s.vnotactive, if_s.frame_start, if_s.frame_cnt);
    end
    m = $urandom_range(20, 200);
    for (int i = 0; i < int'(m); i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (obs_s() !== model_s(c_s)) begin
        n_err++; $display("FAIL mid_post c=%0d got %h want %h", c_s, obs_s(), model_s(c_s));
      end
    end
  endtask

  task automatic test_reset_at_wrap();
    rst_s = 1'b1;
    @(posedge clk);
    #1;
    rst_s = 1'b0;
    for (int i = 0; i < int'(cyc(SF) - 1); i++) begin
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (obs_s() !== model_s(c_s)) begin
      n_err++; $display("FAIL wrap_pre got %h want %h", obs_s(), model_s(c_s));
    end
    rst_s = 1'b1;
    @(posedge clk);
    #1;
    rst_s = 1'b0;
    n_cmp++;
    if ({if_s.col, if_s.row, if_s.frame_start, if_s.frame_cnt} !== 73'd0) begin
      n_err++; $display("FAIL reset_at_wrap got col=%0d row=%0d fs=%b fc=%0d want zeros",
                        if_s.col, if_s.row, if_s.frame_start, if_s.frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_line_wrap();
    test_frame_wrap();
    test_mid_reset();
    test_reset_at_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
